// File: rtl/echo_timer.sv
// Ultrasonic time-of-flight timer: requests a burst, blanks ring-down, then
// timestamps the first debounced rising echo or reports a listen-window timeout.
module echo_timer #(
    parameter int CNT_W          = 16,
    parameter int BLANK_CYCLES   = 270,
    parameter int TIMEOUT_CYCLES = 65000,
    parameter int DEBOUNCE       = 4
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             start,
    input  logic             burst_finish,
    input  logic             echo_in,
    output logic             burst_en,
    output logic             burst_rstn,
    output logic [CNT_W-1:0] tof_count,
    output logic             tof_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, WAIT_BURST, BLANK, LISTEN, DONE} state_t;

    localparam int               RUN_W        = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_QUAL     = RUN_W'(DEBOUNCE);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cand, cand_now;
    logic [RUN_W-1:0] run, run_now;
    logic             echo_meta, echo_s, echo_prev;
    logic             echo_rise, qualify, expire;

    // echo_prev keeps running through BLANK so a level held across the
    // blank boundary is never mistaken for a rising edge.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each flop take the previous
            // stage's old value, which is what makes this a 2-flop chain.
            echo_meta <= echo_in;
            echo_s    <= echo_meta;
            echo_prev <= echo_s;
        end
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Run length as of this cycle; a fresh rise restarts the candidate.
    always_comb begin
        echo_rise = echo_s & ~echo_prev;
        cand_now  = echo_rise ? cnt : cand;
        if (echo_rise)                 run_now = RUN_W'(1);
        else if (echo_s && run != '0)  run_now = run + RUN_W'(1);
        else                           run_now = '0;
        qualify = (state == LISTEN) && (run_now == RUN_QUAL);
        expire  = (state == LISTEN) && (cnt == TIMEOUT_LAST) && !qualify;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        unique case (state)
            IDLE:       if (start)              state_nxt = WAIT_BURST;
            WAIT_BURST: if (burst_finish)       state_nxt = BLANK;
            BLANK:      if (cnt == BLANK_LAST)  state_nxt = LISTEN;
            LISTEN:     if (qualify || expire)  state_nxt = DONE;
            DONE:                               state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        burst_en   = (state == WAIT_BURST);
        burst_rstn = (state != DONE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cand      <= '0;
            run       <= '0;
            tof_count <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tof_valid <= qualify;
            timeout   <= expire;
            if (qualify) tof_count <= cand_now;

            if (state == BLANK || state == LISTEN) cnt <= cnt + CNT_W'(1);
            else                                   cnt <= '0;

            if (state == LISTEN) begin
                cand <= cand_now;
                run  <= run_now;
            end else begin
                cand <= '0;
                run  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_echo_timer.sv
// Randomized and directed bench for echo_timer against a window-scan model
// of the echo qualification rules.
module tb_echo_timer;

    localparam int CNT_W = 16;
    localparam int BLANK = 10;
    localparam int TMO   = 100;
    localparam int DEB   = 3;

    logic             gclk = 1'b0;
    logic             rst, start, burst_finish, echo_in;
    logic             burst_en, burst_rstn, tof_valid, timeout, busy;
    logic [CNT_W-1:0] tof_count;

    int               n_checks = 0;
    int               n_pass   = 0;
    bit               pat [0:127];   // echo_s value indexed by cnt
    int               exp_tof;

    always #5 gclk = ~gclk;

    echo_timer #(
        .CNT_W          (CNT_W),
        .BLANK_CYCLES   (BLANK),
        .TIMEOUT_CYCLES (TMO),
        .DEBOUNCE       (DEB)
    ) dut (
        .gclk         (gclk),
        .rst          (rst),
        .start        (start),
        .burst_finish (burst_finish),
        .echo_in      (echo_in),
        .burst_en     (burst_en),
        .burst_rstn   (burst_rstn),
        .tof_count    (tof_count),
        .tof_valid    (tof_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".busy"},       busy,       0);
        check({name, ".burst_en"},   burst_en,   0);
        check({name, ".burst_rstn"}, burst_rstn, 1);
        check({name, ".tof_count"},  tof_count,  0);
        check({name, ".tof_valid"},  tof_valid,  0);
        check({name, ".timeout"},    timeout,    0);
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 128; i++) pat[i] = 1'b0;
    endtask

    task automatic set_high(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) pat[i] = 1'b1;
    endtask

    task automatic rand_pat();
        int  i;
        int  len;
        bit  lvl;
        clear_pat();
        i   = 2;
        lvl = 1'b0;
        while (i < 128) begin
            len = lvl ? $urandom_range(1, 5) : $urandom_range(1, 40);
            for (int k = 0; k < len && i < 128; k++) begin
                pat[i] = lvl;
                i++;
            end
            lvl = !lvl;
        end
    endtask

    // Earliest rise inside the listen window whose high run lasts DEB samples
    // without leaving the window wins; otherwise the window times out.
    // ev is the cycle (counted from cnt=0) in which the strobe is visible.
    function automatic void predict(output int ev, output bit qual, output int cand);
        bit ok;
        qual = 1'b0;
        cand = 0;
        ev   = TMO;
        for (int j = BLANK; j + DEB - 1 <= TMO - 1; j++) begin
            ok = pat[j] && !pat[j-1];
            for (int k = 1; k < DEB; k++) ok = ok && pat[j+k];
            if (ok) begin
                qual = 1'b1;
                cand = j;
                ev   = j + DEB;
                return;
            end
        end
    endfunction

    task automatic measure(input string name, input int rst_at, input bit hold_start);
        int ev;
        int cand;
        bit qual;
        predict(ev, qual, cand);

        start = 1'b1;
        tick();
        start = hold_start;
        check({name, ".wb_busy"}, busy, 1);
        repeat ($urandom_range(0, 5)) begin
            check({name, ".wb_burst_en"}, burst_en, 1);
            if (!hold_start) start = 1'($urandom_range(0, 1));
            tick();
        end
        check({name, ".wb_burst_en"}, burst_en, 1);

        burst_finish = 1'b1;
        echo_in      = pat[1];
        tick();

        for (int t = 0; t <= ev + 1; t++) begin
            echo_in      = pat[t+2];
            burst_finish = 1'($urandom_range(0, 1));
            start        = (t <= ev) ? 1'($urandom_range(0, 1)) : hold_start;
            if (hold_start) start = 1'b1;

            if (t == rst_at) begin
                start = 1'b0;
                #2 rst = 1'b1;
                #1;
                check_reset_values({name, ".async_rst"});
                echo_in      = 1'b0;
                burst_finish = 1'b0;
                tick();
                check({name, ".rst_tof_valid"}, tof_valid, 0);
                check({name, ".rst_timeout"},   timeout,   0);
                rst     = 1'b0;
                exp_tof = 0;
                tick();
                check_reset_values({name, ".post_rst"});
                return;
            end

            if (t == ev && qual) exp_tof = cand;
            check({name, ".tof_valid"},  tof_valid,  (t == ev) && qual);
            check({name, ".timeout"},    timeout,    (t == ev) && !qual);
            check({name, ".burst_rstn"}, burst_rstn, t != ev);
            check({name, ".busy"},       busy,       t <= ev);
            check({name, ".burst_en"},   burst_en,   0);
            check({name, ".tof_count"},  tof_count,  exp_tof);
            tick();
        end
        burst_finish = 1'b0;
        echo_in      = 1'b0;

        if (hold_start) begin
            // One IDLE cycle has passed; the held start must now be accepted.
            check({name, ".restart_busy"},     busy,     1);
            check({name, ".restart_burst_en"}, burst_en, 1);
            start = 1'b0;
            rst   = 1'b1;
            #1;
            check_reset_values({name, ".abort_wb"});
            tick();
            rst     = 1'b0;
            exp_tof = 0;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        burst_finish = 1'b0;
        echo_in      = 1'b0;
        exp_tof      = 0;
        #3;
        check_reset_values("reset");
        repeat (2) @(posedge gclk);
        #1 rst = 1'b0;
        tick();
        check_reset_values("idle");

        clear_pat(); set_high(40, 45);                    measure("basic", -1, 0);
        clear_pat(); set_high(3, 15); set_high(30, 32);   measure("span_blank", -1, 0);
        clear_pat(); set_high(20, 21); set_high(50, 55);  measure("glitch", -1, 0);
        clear_pat();                                      measure("no_echo", -1, 0);
        clear_pat(); set_high(97, 120);                   measure("qual_at_limit", -1, 0);
        clear_pat(); set_high(98, 120);                   measure("too_late", -1, 0);
        clear_pat(); set_high(10, 12);                    measure("first_listen", -1, 0);
        clear_pat(); set_high(9, 20); set_high(40, 42);   measure("held_at_exit", -1, 0);
        clear_pat(); set_high(15, 17);                    measure("pre_rst", -1, 0);
        clear_pat(); set_high(24, 30);                    measure("rst_listen", 25, 0);
        clear_pat(); set_high(60, 62);                    measure("after_rst", -1, 0);
        clear_pat(); set_high(33, 40);                    measure("hold_start", -1, 1);

        for (int n = 0; n < 30; n++) begin
            rand_pat();
            measure($sformatf("rand%0d", n), -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/echo_timer.md
ECHO_TIMER -- requirements
Module: echo_timer

Interface
REQ-001 Parameter CNT_W, default 16, width of time-of-flight counter and result.
REQ-002 Parameter BLANK_CYCLES, default 270, cycles after burst end during which echo is ignored (10 us at 27 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 65000, counter value ending the listen window; SHALL be < 2^CNT_W and > BLANK_CYCLES.
REQ-004 Parameter DEBOUNCE, default 4, consecutive high samples needed to qualify an echo; SHALL be >= 1.
REQ-005 gclk  input  1  system clock, 27 MHz, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  synchronous measurement request from main; level or pulse, edge not required.
REQ-008 burst_finish  input  1  from pulse generator, high while burst is complete.
REQ-009 echo_in  input  1  asynchronous receive-comparator output, high = echo energy present.
REQ-010 burst_en  output  1  held high to pulse generator while burst requested.
REQ-011 burst_rstn  output  1  active-low re-arm strobe to pulse generator.
REQ-012 tof_count  output  CNT_W  measured time of flight in gclk cycles.
REQ-013 tof_valid  output  1  one-cycle strobe, tof_count updated.
REQ-014 timeout  output  1  one-cycle strobe, no echo in window.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 echo_in SHALL pass a two-flop synchronizer; echo_s denotes the second flop; all echo decisions use echo_s only.
REQ-017 States SHALL be IDLE, WAIT_BURST, BLANK, LISTEN, DONE.
REQ-018 IDLE: start=1 -> WAIT_BURST next cycle; burst_en rises same edge.
REQ-019 WAIT_BURST: burst_en=1; on first cycle burst_finish sampled high -> BLANK, cnt loaded 0, burst_en drops same edge.
REQ-020 cnt SHALL increment by 1 every cycle in BLANK and LISTEN; cleared in IDLE.
REQ-021 BLANK: when cnt==BLANK_CYCLES-1 -> LISTEN; echo_s ignored entirely.
REQ-022 LISTEN: a candidate run starts only on a rising edge of echo_s (echo_s=1, previous echo_s=0) seen in LISTEN; a level already high at BLANK exit SHALL be ignored until it falls.
REQ-023 On candidate start, cnt value of that cycle SHALL be captured as cand; run length counts from 1.
REQ-024 echo_s falling before run length reaches DEBOUNCE SHALL discard cand; next rising edge starts a new candidate.
REQ-025 Run length reaching DEBOUNCE -> tof_count<=cand, tof_valid=1 for one cycle, -> DONE.
REQ-026 cnt==TIMEOUT_CYCLES-1 in LISTEN without qualification -> timeout=1 for one cycle, tof_count unchanged, -> DONE.
REQ-027 Qualification and timeout in same cycle: qualification wins, timeout SHALL stay 0.
REQ-028 DONE: burst_rstn=0 for exactly one cycle, then -> IDLE; burst_rstn=1 all other times.
REQ-029 start while busy SHALL be ignored; start held high in DONE causes a new measurement only after one cycle in IDLE.
REQ-030 tof_valid and timeout SHALL never be high together and never high outside the LISTEN->DONE transition cycle.
REQ-031 tof_count SHALL hold its value until the next qualified echo.

Reset
REQ-032 rst high SHALL immediately force IDLE, cnt=0, synchronizer flops=0, burst_en=0, burst_rstn=1, tof_count=0, tof_valid=0, timeout=0, busy=0.
REQ-033 rst mid-measurement SHALL abort with no tof_valid or timeout strobe; after release the block waits for a fresh start.

Verification (BLANK_CYCLES=10, TIMEOUT_CYCLES=100, DEBOUNCE=3)
REQ-034 start pulse, burst_finish high 5 cycles later, echo_s rises at cnt=40 and stays 6 cycles -> tof_valid at cnt=42 cycle, tof_count=40, burst_rstn low 1 cycle, busy falls.
REQ-035 echo_s high cnt=3..15 (spans blank) then rises again at cnt=30 for 3 cycles -> tof_count=30.
REQ-036 echo_s glitch 2 cycles at cnt=20, valid run at cnt=50 -> tof_count=50, one tof_valid only.
REQ-037 No echo -> timeout strobe on cnt=99 cycle, tof_count retains prior value, tof_valid=0.
REQ-038 Run reaching DEBOUNCE exactly at cnt=99 (rise at 97) -> tof_valid=1, tof_count=97, timeout=0.
REQ-039 rst asserted at cnt=25 in LISTEN -> all outputs to reset values asynchronously, no strobes; second start after release completes normally.
